// File: rtl/logic_op_pipe.sv
// ============================================================================
//  Module   : logic_op_pipe
//  Summary  : Two-stage handshaked pipeline. It computes bitwise logic
//             functions (AND/OR/NAND/NOR/XOR/XNOR/NOT) and registers the
//             zero, parity and illegal-opcode flags.
//  Options  : LOGIC_OP_PIPE_STATS_EN adds saturating transfer/error counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_op_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic             out_err
`ifdef LOGIC_OP_PIPE_STATS_EN
    ,
    output logic [15:0]      txn_count,
    output logic [15:0]      err_count
`endif
);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_NAND = 3'd2;
    localparam logic [2:0] c_OP_NOR  = 3'd3;
    localparam logic [2:0] c_OP_XOR  = 3'd4;
    localparam logic [2:0] c_OP_XNOR = 3'd5;
    localparam logic [2:0] c_OP_NOT  = 3'd6;

    // Stage 1: captured operands and opcode
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;

    // Stage 2: registered result and flags
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic             r_s2_zero;
    logic             r_s2_parity;
    logic             r_s2_err;

    logic             w_s2_ready;
    logic             w_s1_ready;
    logic             w_accept;
    logic             w_s1_move;
    logic             w_xfer;
    logic [WIDTH-1:0] w_result;
    logic             w_err;

    // The ready chain looks only at stage occupancy and out_ready. It never
    // looks at in_valid, so no combinational loop can form through the source.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_accept   = in_valid && w_s1_ready;
    assign w_s1_move  = r_s1_valid && w_s2_ready;
    assign w_xfer     = r_s2_valid && out_ready;

    // Opcode decode from stage-1 registers; illegal opcode yields all zeros
    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_s1_op)
            c_OP_AND:  w_result = r_s1_a & r_s1_b;
            c_OP_OR:   w_result = r_s1_a | r_s1_b;
            c_OP_NAND: w_result = ~(r_s1_a & r_s1_b);
            c_OP_NOR:  w_result = ~(r_s1_a | r_s1_b);
            c_OP_XOR:  w_result = r_s1_a ^ r_s1_b;
            c_OP_XNOR: w_result = ~(r_s1_a ^ r_s1_b);
            c_OP_NOT:  w_result = ~r_s1_a;
            default: begin
                w_result = '0;
                w_err    = 1'b1;
            end
        endcase
    end

    // Stage-1 occupancy: refill (or drain) whenever the slot is free or moving on
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    // Stage-1 data capture. The contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_a  <= in_a;
            r_s1_b  <= in_b;
            r_s1_op <= in_op;
        end
    end

    // Stage-2 occupancy: follows stage 1 whenever the output slot can take data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    // Stage-2 result and flags; held during output stalls, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_result <= '0;
            r_s2_zero   <= 1'b0;
            r_s2_parity <= 1'b0;
            r_s2_err    <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_result <= w_result;
            r_s2_zero   <= (w_result == '0);
            r_s2_parity <= ^w_result;
            r_s2_err    <= w_err;
        end
    end

    assign in_ready   = w_s1_ready;
    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_zero   = r_s2_zero;
    assign out_parity = r_s2_parity;
    assign out_err    = r_s2_err;

`ifdef LOGIC_OP_PIPE_STATS_EN
    logic [15:0] r_txn_count;
    logic [15:0] r_err_count;

    // Saturating counters of completed output transfers and of errored ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn_count <= 16'd0;
            r_err_count <= 16'd0;
        end else if (w_xfer) begin
            if (r_txn_count != 16'hFFFF) begin
                r_txn_count <= r_txn_count + 16'd1;
            end
            if (r_s2_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign txn_count = r_txn_count;
    assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_op_pipe.sv
// ============================================================================
//  Module   : tb_logic_op_pipe
//  Summary  : Scoreboard bench for logic_op_pipe. It runs directed vectors,
//             stall and reset scenarios and a randomized handshake run,
//             and checks every transfer against a behavioural model.
//             The counter checks are active when LOGIC_OP_PIPE_STATS_EN
//             is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_logic_op_pipe;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         p;
        logic         e;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_parity;
    logic         out_err;
`ifdef LOGIC_OP_PIPE_STATS_EN
    logic [15:0]  txn_count;
    logic [15:0]  err_count;
`endif

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     m_txn = 0;
    int     m_err = 0;
    bit     chk_lat = 1'b0;
    bit     rand_mode = 1'b0;
    bit     forced_or = 1'b1;
    exp_t   exp_q[$];
    logic [W-1:0] hold_res;

    logic_op_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .out_err    (out_err)
`ifdef LOGIC_OP_PIPE_STATS_EN
        ,
        .txn_count  (txn_count),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: opcode table applied with plain operators
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op);
        exp_t r;
        case (op)
            3'd0: r.res = a & b;
            3'd1: r.res = a | b;
            3'd2: r.res = ~(a & b);
            3'd3: r.res = ~(a | b);
            3'd4: r.res = a ^ b;
            3'd5: r.res = ~(a ^ b);
            3'd6: r.res = ~a;
            default: r.res = '0;
        endcase
        r.e   = (op == 3'd7);
        r.z   = (r.res == 0);
        r.p   = ($countones(r.res) % 2) == 1;
        r.cyc = 0;
        return r;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected data on each output transfer, pushes on each accept
    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                m_txn++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {out_result, out_err}, 0);
                    fails += (({out_result, out_err} == 0) ? 1 : 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.e) m_err++;
                    chk("result_flags", {out_result, out_zero, out_parity, out_err},
                        {e.res, e.z, e.p, e.e});
                    if (chk_lat) chk("latency", cyc, e.cyc + 2);
                end
            end
            if (!rst && in_valid && in_ready) begin
                e = model(in_a, in_b, in_op);
                e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_out_ready();
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : forced_or;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        m_txn = 0;
        m_err = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bit ok;
        ok = 1'b0;
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
        #2;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", {out_zero, out_parity, out_err}, 0);
`ifdef LOGIC_OP_PIPE_STATS_EN
        chk("rst_counters", {txn_count, err_count}, 0);
`endif
    endtask

    initial begin
        fork
            run_monitor();
            run_out_ready();
            begin
                #950000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        do_reset(2);
        check_reset_state();

        // Directed opcode sweep, back-to-back with out_ready held high
        idle(1);
        chk_lat = 1'b1;
        for (int op = 0; op < 7; op++) send(8'h0F, 8'h3C, 3'(op));
        idle(1);
        drain();
        chk_lat = 1'b0;

        // Zero result and illegal opcode
        send(8'hA5, 8'hA5, 3'd4);
        send(8'hFF, 8'hFF, 3'd7);
        idle(1);
        drain();
`ifdef LOGIC_OP_PIPE_STATS_EN
        chk("err_count_illegal", err_count, 1);
`endif

        // Stall: three offered, two buffered, outputs held stable
        forced_or = 1'b0;
        idle(3);
        in_a = 8'h11; in_b = 8'h22; in_op = 3'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("stall_accept1", in_ready, 1);
        @(posedge clk); #1;
        in_a = 8'h33; in_b = 8'h0F; in_op = 3'd0;
        @(negedge clk);
        chk("stall_accept2", in_ready, 1);
        @(posedge clk); #1;
        in_a = 8'h5A; in_b = 8'hFF; in_op = 3'd4;
        @(negedge clk);
        chk("stall_in_ready_low", in_ready, 0);
        chk("stall_buffered", exp_q.size(), 2);
        chk("stall_out_valid", out_valid, 1);
        hold_res = out_result;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold_ready", in_ready, 0);
            chk("stall_hold_result", {out_valid, out_result}, {1'b1, hold_res});
        end
        @(posedge clk); #1;
        forced_or = 1'b1;
        send(8'h5A, 8'hFF, 3'd4);
        idle(1);
        drain();

        // Reset while full: pre-reset data must never appear
        forced_or = 1'b0;
        idle(2);
        send(8'hC3, 8'h81, 3'd2);
        send(8'h7E, 8'h18, 3'd5);
        rst = 1'b1;
        in_valid = 1'b0;
        forced_or = 1'b1;
        exp_q.delete();
        m_txn = 0;
        m_err = 0;
        @(posedge clk);
        #2;
        check_reset_state();
        rst = 1'b0;
        idle(6);
        chk("post_reset_no_output", m_txn, 0);

        // Randomized handshake run against the model
        do_reset(2);
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        end
        idle(1);
        rand_mode = 1'b0;
        forced_or = 1'b1;
        drain();
        chk("random_txn_observed", m_txn, 1000);
`ifdef LOGIC_OP_PIPE_STATS_EN
        chk("txn_count_1000", txn_count, 1000);
        chk("err_count_random", err_count, m_err);

        // Saturation of the transfer counter
        do_reset(2);
        for (int i = 0; i < 65537; i++) send(8'h01, 8'h02, 3'd1);
        idle(1);
        drain();
        chk("sat_observed", m_txn, 65537);
        chk("txn_count_sat", txn_count, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
